// File: rtl/dmem_responder.sv
// Data-memory responder: byte/half/word loads and stores on a 2**ADDR_WIDTH word array; DMEM_STATS_EN adds counters.
// Latency: good request responds WAIT_STATES+2 cycles after handshake, errors after 1 cycle.
// Backpressure: response held in RESP until rsp_ready_in; no new request accepted meanwhile.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        req_valid_in,
  output logic        req_ready_out,
  input  logic        wr_req_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  input  logic [1:0]  size_in,
  input  logic        load_unsigned_in,
  output logic        rsp_valid_out,
  input  logic        rsp_ready_in,
  output logic [31:0] rdata_out,
  output logic        err_out,
  output logic        busy_out
`ifdef DMEM_STATS_EN
  ,
  output logic [15:0] ld_count_out,
  output logic [15:0] st_count_out,
  output logic [15:0] err_count_out
`endif
);

  localparam int AHI = ADDR_WIDTH + 2;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  state_t state, state_nxt;

  logic                  wr_q;
  logic [AHI-1:0]        addr_q;
  logic [31:0]           wdata_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [3:0]            wait_cnt;
  logic [31:0]           rdata_q;
  logic                  err_q;

  logic                  req_fire;
  logic                  rsp_fire;
  logic                  req_err;
  logic                  mem_we;
  logic [1:0]            lane;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [3:0]            be;
  logic [31:0]           wd;
  logic [31:0]           rd_word;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [31:0]           load_data;

  logic [31:0] mem [0:(2**ADDR_WIDTH)-1];

  assign req_ready_out = (state == IDLE) && !rst_in;
  assign rsp_valid_out = (state == RESP);
  assign busy_out      = (state != IDLE);
  assign rdata_out     = rdata_q;
  assign err_out       = err_q;

  assign req_fire = req_valid_in && req_ready_out;
  assign rsp_fire = (state == RESP) && rsp_ready_in;

  // Misaligned, illegal size, or bits above the array span.
  assign req_err = (size_in == 2'b11)
                 || ((size_in == 2'b01) && addr_in[0])
                 || ((size_in == 2'b10) && (addr_in[1:0] != 2'b00))
                 || (|addr_in[31:AHI]);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_fire) begin
          if (req_err)              state_nxt = RESP;
          else if (WAIT_STATES > 0) state_nxt = WAIT;
          else                      state_nxt = ACCESS;
        end
      end
      WAIT:    if (wait_cnt == 4'd0) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    if (rsp_ready_in) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign lane     = addr_q[1:0];
  assign word_idx = addr_q[AHI-1:2];
  assign mem_we   = (state == ACCESS) && wr_q && !rst_in;

  // Store data is replicated across lanes so the byte enables alone pick placement.
  always_comb begin
    be = 4'b1111;
    wd = wdata_q;
    case (size_q)
      2'b00: begin
        be = 4'b0001 << lane;
        wd = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be = addr_q[1] ? 4'b1100 : 4'b0011;
        wd = {2{wdata_q[15:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = wdata_q;
      end
    endcase
  end

  assign rd_word  = mem[word_idx];
  assign byte_sel = rd_word[8*lane +: 8];
  assign half_sel = addr_q[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_data = rd_word;
    case (size_q)
      2'b00:   load_data = {{24{~uns_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_data = {{16{~uns_q & half_sel[15]}}, half_sel};
      default: load_data = rd_word;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[word_idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (req_fire) begin
        wr_q     <= wr_req_in;
        addr_q   <= addr_in[AHI-1:0];
        wdata_q  <= wdata_in;
        size_q   <= size_in;
        uns_q    <= load_unsigned_in;
        err_q    <= req_err;
        wait_cnt <= 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (state == ACCESS) rdata_q <= wr_q ? 32'd0 : load_data;
      if (rsp_fire) begin
        rdata_q <= 32'd0;
        err_q   <= 1'b0;
      end
    end
  end

`ifdef DMEM_STATS_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ld_count_out  <= 16'd0;
      st_count_out  <= 16'd0;
      err_count_out <= 16'd0;
    end else if (rsp_fire) begin
      if (err_q) begin
        if (err_count_out != 16'hFFFF) err_count_out <= err_count_out + 16'd1;
      end else if (wr_q) begin
        if (st_count_out != 16'hFFFF) st_count_out <= st_count_out + 16'd1;
      end else begin
        if (ld_count_out != 16'hFFFF) ld_count_out <= ld_count_out + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboarded bench for dmem_responder with ADDR_WIDTH=10, WAIT_STATES=1.
module tb_dmem_responder;

  localparam int AW = 10;
  localparam int WS = 1;
  localparam int GOOD_LAT = WS + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        wr_req;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  size;
  logic        uns;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rdata;
  logic        err;
  logic        busy;
`ifdef DMEM_STATS_EN
  logic [15:0] ld_cnt, st_cnt, err_cnt;
`endif

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(WS)) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .req_valid_in    (req_valid),
    .req_ready_out   (req_ready),
    .wr_req_in       (wr_req),
    .addr_in         (addr),
    .wdata_in        (wdata),
    .size_in         (size),
    .load_unsigned_in(uns),
    .rsp_valid_out   (rsp_valid),
    .rsp_ready_in    (rsp_ready),
    .rdata_out       (rdata),
    .err_out         (err),
    .busy_out        (busy)
`ifdef DMEM_STATS_EN
    ,
    .ld_count_out    (ld_cnt),
    .st_count_out    (st_cnt),
    .err_count_out   (err_cnt)
`endif
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Presents one request and returns just after its handshake edge.
  task automatic drive_req(input string name, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [1:0] s, input logic u);
    int guard = 0;
    wr_req = w; addr = a; wdata = d; size = s; uns = u;
    req_valid = 1'b1;
    while (!req_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s accept: req_ready=%b required 1", name, req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic run_xact(input string name, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [1:0] s, input logic u,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input int exp_lat, input int hold);
    int   lat;
    exp_t e;
    sb.push_back('{exp_rdata, exp_err});
    rsp_ready = (hold == 0);
    drive_req(name, w, a, d, s, u);
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    e = sb.pop_front();
    total++;
    if (lat != exp_lat) begin
      bad++;
      $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
    end
    total++;
    if ({err, rdata} !== {e.err, e.rdata}) begin
      bad++;
      $display("FAIL %s rsp: err=%b rdata=%h required err=%b rdata=%h", name, err, rdata, e.err, e.rdata);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      total++;
      if ({rsp_valid, err, rdata, req_ready} !== {1'b1, e.err, e.rdata, 1'b0}) begin
        bad++;
        $display("FAIL %s hold%0d: valid=%b err=%b rdata=%h ready=%b required 1 %b %h 0",
                 name, i, rsp_valid, err, rdata, req_ready, e.err, e.rdata);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({rsp_valid, err, rdata, req_ready, busy} !== {1'b0, 1'b0, 32'h0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL %s release: valid=%b err=%b rdata=%h ready=%b busy=%b required 0 0 0 1 0",
               name, rsp_valid, err, rdata, req_ready, busy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({req_ready, rsp_valid, err, rdata, busy} !== 36'h0) begin
      bad++;
      $display("FAIL reset_hold: ready=%b valid=%b err=%b rdata=%h busy=%b required all 0",
               req_ready, rsp_valid, err, rdata, busy);
    end
    rst = 1'b0;
    #1;
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release: req_ready=%b required 1", req_ready);
    end
`ifdef DMEM_STATS_EN
    total++;
    if ({ld_cnt, st_cnt, err_cnt} !== 48'h0) begin
      bad++;
      $display("FAIL reset_counts: ld=%0d st=%0d err=%0d required 0", ld_cnt, st_cnt, err_cnt);
    end
`endif
  endtask

  task automatic test_store_load;
    run_xact("st_word",  1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0,        1'b0, GOOD_LAT, 0);
    run_xact("ld_word",  1'b0, 32'h10, 32'h0,        2'b10, 1'b0, 32'hDEADBEEF, 1'b0, GOOD_LAT, 0);
  endtask

  task automatic test_byte_lanes;
    run_xact("st_byte",   1'b1, 32'h11, 32'hFFFFFF80, 2'b00, 1'b0, 32'h0,        1'b0, GOOD_LAT, 0);
    run_xact("ld_byte_s", 1'b0, 32'h11, 32'h0,        2'b00, 1'b0, 32'hFFFFFF80, 1'b0, GOOD_LAT, 0);
    run_xact("ld_byte_u", 1'b0, 32'h11, 32'h0,        2'b00, 1'b1, 32'h00000080, 1'b0, GOOD_LAT, 0);
    run_xact("ld_word2",  1'b0, 32'h10, 32'h0,        2'b10, 1'b0, 32'hDEAD80EF, 1'b0, GOOD_LAT, 0);
  endtask

  task automatic test_half_lanes;
    run_xact("st_w14",    1'b1, 32'h14, 32'h11223344, 2'b10, 1'b0, 32'h0,        1'b0, GOOD_LAT, 0);
    run_xact("st_half",   1'b1, 32'h16, 32'h5555BEEF, 2'b01, 1'b0, 32'h0,        1'b0, GOOD_LAT, 0);
    run_xact("ld_half_s", 1'b0, 32'h16, 32'h0,        2'b01, 1'b0, 32'hFFFFBEEF, 1'b0, GOOD_LAT, 0);
    run_xact("ld_half_u", 1'b0, 32'h16, 32'h0,        2'b01, 1'b1, 32'h0000BEEF, 1'b0, GOOD_LAT, 0);
    run_xact("ld_half_lo",1'b0, 32'h14, 32'h0,        2'b01, 1'b0, 32'h00003344, 1'b0, GOOD_LAT, 0);
    run_xact("ld_w14",    1'b0, 32'h14, 32'h0,        2'b10, 1'b0, 32'hBEEF3344, 1'b0, GOOD_LAT, 0);
  endtask

  task automatic test_errors;
    run_xact("err_half_mis", 1'b0, 32'h13,       32'h0, 2'b01, 1'b0, 32'h0, 1'b1, 1, 0);
    run_xact("err_range",    1'b0, 32'h00001000, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1, 1, 0);
    run_xact("err_word_mis", 1'b1, 32'h12,       32'hFFFFFFFF, 2'b10, 1'b0, 32'h0, 1'b1, 1, 0);
    run_xact("err_size",     1'b0, 32'h10,       32'h0, 2'b11, 1'b0, 32'h0, 1'b1, 1, 0);
    run_xact("ld_after_err", 1'b0, 32'h10,       32'h0, 2'b10, 1'b0, 32'hDEAD80EF, 1'b0, GOOD_LAT, 0);
  endtask

  task automatic test_backpressure;
    run_xact("bp_load", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hDEAD80EF, 1'b0, GOOD_LAT, 5);
  endtask

  task automatic test_reset_mid;
    run_xact("st_prior", 1'b1, 32'h20, 32'hA5A5A5A5, 2'b10, 1'b0, 32'h0, 1'b0, GOOD_LAT, 0);
    drive_req("st_abort", 1'b1, 32'h20, 32'h12345678, 2'b10, 1'b0);
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL abort_busy: busy=%b required 1", busy);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({req_ready, rsp_valid, err, rdata, busy} !== 36'h0) begin
      bad++;
      $display("FAIL abort_reset: ready=%b valid=%b err=%b rdata=%h busy=%b required all 0",
               req_ready, rsp_valid, err, rdata, busy);
    end
    rst = 1'b0;
    run_xact("ld_prior", 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'hA5A5A5A5, 1'b0, GOOD_LAT, 0);
  endtask

`ifdef DMEM_STATS_EN
  task automatic test_stats;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    run_xact("cnt_ld0", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hDEAD80EF, 1'b0, GOOD_LAT, 0);
    run_xact("cnt_ld1", 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'hA5A5A5A5, 1'b0, GOOD_LAT, 0);
    run_xact("cnt_st",  1'b1, 32'h30, 32'h1, 2'b10, 1'b0, 32'h0,        1'b0, GOOD_LAT, 0);
    run_xact("cnt_err", 1'b0, 32'h31, 32'h0, 2'b10, 1'b0, 32'h0,        1'b1, 1, 0);
    total++;
    if ({ld_cnt, st_cnt, err_cnt} !== {16'd2, 16'd1, 16'd1}) begin
      bad++;
      $display("FAIL stats: ld=%0d st=%0d err=%0d required 2 1 1", ld_cnt, st_cnt, err_cnt);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; req_valid = 1'b0; wr_req = 1'b0; addr = 32'h0;
    wdata = 32'h0; size = 2'b00; uns = 1'b0; rsp_ready = 1'b1;
    test_reset();
    test_store_load();
    test_byte_lanes();
    test_half_lanes();
    test_errors();
    test_backpressure();
    test_reset_mid();
`ifdef DMEM_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder sitting at the far end of the core's load/store request path.
- Accepts one load or store request per handshake: byte address, size (byte/half/word), unsigned-load flag and store data.
- Applies a programmable number of wait states and performs byte-lane writes or sign/zero-extended reads on an internal word array.
- Returns a response carrying read data or an error flag, with valid/ready backpressure.

Parameters:
- ADDR_WIDTH, 10, word-address width; array depth is 2**ADDR_WIDTH 32-bit words.
- WAIT_STATES, 1, idle cycles inserted between request acceptance and memory access (0..15).

Ports:
- clk_in  input  1  single clock; all state updates on rising edge.
- rst_in  input  1  synchronous active-high reset.
- req_valid_in  input  1  request present.
- req_ready_out  output  1  responder accepts a request this cycle.
- wr_req_in  input  1  1=store, 0=load.
- addr_in  input  32  byte address.
- wdata_in  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
- size_in  input  2  00 byte, 01 half, 10 word, 11 illegal.
- load_unsigned_in  input  1  1=zero-extend, 0=sign-extend loads.
- rsp_valid_out  output  1  response present.
- rsp_ready_in  input  1  consumer takes response.
- rdata_out  output  32  load data, extended; 0 for stores and errors.
- err_out  output  1  request was misaligned, illegal-size or out-of-range.
- busy_out  output  1  high in any state other than IDLE.

Behaviour:
- FSM states: IDLE, WAIT, ACCESS, RESP.
- Reset (rst_in high at an edge) forces IDLE. Outputs read as follows:
  - While rst_in is high: req_ready_out=0.
  - From reset and after it: rsp_valid_out=0, rdata_out=0, err_out=0, busy_out=0.
  - Wait counter is cleared. Array contents are not reset.
- req_ready_out=1 only in IDLE with rst_in low. A handshake is req_valid_in & req_ready_out at an edge; all request fields are captured into registers at that edge.
- Error check at capture:
  - size 11 is an error.
  - size 01 with addr[0]=1 is an error.
  - size 10 with addr[1:0]!=00 is an error.
  - Any 1 in addr[31:ADDR_WIDTH+2] is an error.
- Erroring request: IDLE->RESP directly, no array access. rsp_valid_out=1, err_out=1, rdata_out=0 in the next cycle.
- Good request:
  - IDLE->WAIT if WAIT_STATES>0, else IDLE->ACCESS.
  - WAIT lasts exactly WAIT_STATES cycles, then goes to ACCESS.
  - ACCESS lasts one cycle, then goes to RESP.
- Latency: handshake at end of cycle 0 gives rsp_valid_out high from cycle WAIT_STATES+2. Errors respond in cycle 1.
- ACCESS, store: writes only the addressed lanes at the ACCESS edge.
  - Byte: wdata[7:0] goes to lane addr[1:0].
  - Half: wdata[15:0] goes to lanes {addr[1],0} and {addr[1],1}.
  - Word: all four lanes are written.
  - Unaddressed lanes are unchanged.
- ACCESS, load: reads word addr[ADDR_WIDTH+1:2], selects lane(s), and extends to 32 bits per load_unsigned_in. The result is registered into rdata_out at the ACCESS edge.
- Store response: rsp_valid_out=1, rdata_out=0, err_out=0.
- RESP:
  - rsp_valid_out, rdata_out and err_out are held stable until rsp_valid_out & rsp_ready_in at an edge.
  - On that edge: return to IDLE, clear rsp_valid_out/err_out/rdata_out.
  - req_ready_out rises the following cycle; there is no back-to-back acceptance in the response cycle.
- Backpressure: rsp_ready_in low holds RESP indefinitely. No further requests are accepted while held.
- Reset mid-operation:
  - A pending store in WAIT is dropped.
  - If rst_in is high in the ACCESS cycle, the write is suppressed (reset has priority).
  - A pending response is discarded.
- Read-after-write: a load accepted after a store response observes the stored data.

Optional Feature:
- Macro DMEM_STATS_EN.
- When defined, add three outputs: ld_count_out, st_count_out and err_count_out, each 16 bits.
  - Counters increment on the response handshake for good loads, good stores and errors respectively.
  - Counters saturate at 16'hFFFF and are cleared by rst_in.
- When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- WAIT_STATES=1: store word 32'hDEADBEEF at addr 0x10, then load word 0x10 with rsp_ready_in=1 -> rsp_valid_out rises 3 cycles after each handshake; load returns rdata_out=32'hDEADBEEF, err_out=0.
- After the above, store byte 8'h80 to 0x11, then load byte signed 0x11 -> 32'hFFFFFF80. Load byte unsigned 0x11 -> 32'h00000080. Load word 0x10 -> 32'hDEAD80EF.
- Load half at 0x13 -> err_out=1, rdata_out=0, response 1 cycle after handshake, memory unchanged. Load word at addr 0x00001000 with ADDR_WIDTH=10 -> err_out=1.
- Backpressure: hold rsp_ready_in=0 for 5 cycles during a load response -> rsp_valid_out and rdata_out stable; req_ready_out=0 throughout; IDLE reached one cycle after rsp_ready_in=1.
- Assert rst_in during the ACCESS cycle of a store word 32'h12345678 to 0x20 -> subsequent load of 0x20 returns the prior contents; all outputs reset values next cycle.
- With DMEM_STATS_EN: 2 loads, 1 store, 1 error completed -> ld_count_out=2, st_count_out=1, err_count_out=1.
